// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Sample-rate scheduler and mixer for the wavetable voice generators.
//   A free-running divider produces one tick every clk_per_sample_p cycles.
//   Each accepted tick pulses step_o once for every enabled voice. The
//   scheduler then waits one cycle for the generators' registered outputs to
//   settle and sums the voices one per cycle into a signed mixed sample. The
//   sample is offered downstream on a valid/ready handshake.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   enable_i     runs the sample-tick divider (in-flight sample always completes)
//   voice_en_i   per-voice enable, captured at an accepted tick
//   gen_data_i   voice samples, voice i at [i*width_p +: width_p]
//   step_o       one-cycle advance pulse per enabled voice
//   mix_data_o   signed mixed sample, width_p+$clog2(voices_p) bits
//   mix_valid_o  mixed sample valid
//   mix_ready_i  downstream accepts the sample
//   busy_o       scheduler is working on a sample (state is not IDLE)
//   overrun_o    sticky: a tick arrived while busy and was dropped
//
// Handshake: mix_data_o is transferred in a cycle where mix_valid_o and
// mix_ready_i are both high. Once raised, mix_valid_o stays high and
// mix_data_o stays stable until that transfer; mix_valid_o never depends
// on mix_ready_i.
module voice_scheduler #(
   parameter int width_p          = 12,
   parameter int voices_p         = 4,
   parameter int clk_per_sample_p = 2268
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  enable_i,
   input  logic [voices_p-1:0]                   voice_en_i,
   input  logic [voices_p*width_p-1:0]           gen_data_i,
   output logic [voices_p-1:0]                   step_o,
   output logic [width_p+$clog2(voices_p)-1:0]   mix_data_o,
   output logic                                  mix_valid_o,
   input  logic                                  mix_ready_i,
   output logic                                  busy_o,
   output logic                                  overrun_o
);

   localparam int mw = width_p + $clog2(voices_p);
   localparam int cw = (clk_per_sample_p > 1) ? $clog2(clk_per_sample_p) : 1;
   localparam int iw = (voices_p > 1) ? $clog2(voices_p) : 1;
   localparam logic [cw-1:0] cnt_last = cw'(clk_per_sample_p - 1);
   localparam logic [iw-1:0] idx_last = iw'(voices_p - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STEP   = 3'd1,
      SETTLE = 3'd2,
      ACCUM  = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [cw-1:0]         cnt_q;
   logic                  tick;
   logic [voices_p-1:0]   en_q;
   logic [iw-1:0]         idx_q;
   logic [mw-1:0]         acc_q;
   logic [mw-1:0]         acc_sum;
   logic [mw-1:0]         mix_q;
   logic                  overrun_q;
   logic signed [width_p-1:0] cur_sample;
   logic [mw-1:0]         cur_term;

   // ---------------------------------------------------------------------
   // Sample-rate divider. Held at 0 while disabled so the first tick after
   // enabling lands exactly clk_per_sample_p-1 cycles later.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i || !enable_i || cnt_q == cnt_last) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + cw'(1);
      end
   end

   assign tick = enable_i && (cnt_q == cnt_last);

   // ---------------------------------------------------------------------
   // Voice selection for the accumulate step. A disabled voice adds zero;
   // the signed cast sign-extends the voice sample to the mix width.
   // ---------------------------------------------------------------------
   always_comb begin
      cur_sample = gen_data_i[idx_q*width_p +: width_p];
      cur_term   = en_q[idx_q] ? mw'(cur_sample) : '0;
      acc_sum    = acc_q + cur_term;
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      step_o      = '0;
      mix_valid_o = 1'b0;
      busy_o      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (tick) state_d = STEP;
         end
         STEP: begin
            step_o  = en_q;
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = ACCUM;
         end
         ACCUM: begin
            if (idx_q == idx_last) state_d = OUT;
         end
         OUT: begin
            mix_valid_o = 1'b1;
            if (mix_ready_i) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: enable capture, accumulator, output register, overrun flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         en_q      <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         mix_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         // Any tick that finds the scheduler busy is lost; remember it.
         if (tick && state_q != IDLE) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick) begin
                  en_q  <= voice_en_i;
                  acc_q <= '0;
               end
            end
            SETTLE: begin
               idx_q <= '0;
            end
            ACCUM: begin
               acc_q <= acc_sum;
               idx_q <= idx_q + iw'(1);
               // Load the output register with the completed sum as we leave.
               if (idx_q == idx_last) mix_q <= acc_sum;
            end
            default: begin
            end
         endcase
      end
   end

   assign mix_data_o = mix_q;
   assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler
//   Bench for voice_scheduler with voices_p=2, clk_per_sample_p=16.
//   A timeline model (cycles since the accepted tick) predicts every output
//   each cycle; a queue of hand-computed mixed samples is matched against
//   each handshake.
module tb_voice_scheduler;

   localparam int W   = 12;
   localparam int V   = 2;
   localparam int CPS = 16;
   localparam int MW  = 13;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [V-1:0]    voice_en;
   logic [V*W-1:0]  gen_data;
   logic [V-1:0]    step;
   logic [MW-1:0]   mix_data;
   logic            mix_valid;
   logic            mix_ready;
   logic            busy;
   logic            overrun;

   int              checks = 0;
   int              errors = 0;
   int              cyc    = 0;
   bit              done   = 1'b0;
   logic [MW-1:0]   exp_q[$];

   // model state
   int              m_cnt  = 0;
   int              m_age  = 0;
   int              m_sum  = 0;
   bit              m_busy = 1'b0;
   bit              m_ovr  = 1'b0;
   logic [V-1:0]    m_en   = '0;
   logic [MW-1:0]   m_mix  = '0;

   // ---------------------------------------------------------------------
   // clock / reset
   // ---------------------------------------------------------------------
   always #5 clk = ~clk;

   voice_scheduler #(
      .width_p         (W),
      .voices_p        (V),
      .clk_per_sample_p(CPS)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .enable_i   (enable),
      .voice_en_i (voice_en),
      .gen_data_i (gen_data),
      .step_o     (step),
      .mix_data_o (mix_data),
      .mix_valid_o(mix_valid),
      .mix_ready_i(mix_ready),
      .busy_o     (busy),
      .overrun_o  (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // scoreboard / compare process (sampled on the falling edge)
   // ---------------------------------------------------------------------
   initial begin
      logic        tick;
      bit          nb;
      int          i;
      logic [W-1:0] d;
      logic [MW-1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         chk("busy",      busy,      m_busy);
         chk("step",      step,      (m_busy && m_age == 1) ? m_en : '0);
         chk("mix_valid", mix_valid, m_busy && m_age >= 3 + V);
         chk("mix_data",  mix_data,  m_mix);
         chk("overrun",   overrun,   m_ovr);
         if (mix_valid && mix_ready) begin
            chk("sample_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sample_literal", mix_data, e);
            end
         end
         if (done) begin
            chk("samples_left", exp_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         // advance the model by the inputs applied in this cycle
         if (reset) begin
            m_cnt = 0; m_busy = 0; m_age = 0; m_en = '0;
            m_sum = 0; m_mix = '0; m_ovr = 0;
         end else begin
            tick = enable && (m_cnt == CPS - 1);
            nb   = m_busy;
            if (m_busy) begin
               if (m_age >= 3 && m_age <= 2 + V) begin
                  i = m_age - 3;
                  d = gen_data[i*W +: W];
                  if (m_en[i]) m_sum += d[W-1] ? (int'(d) - (1 << W)) : int'(d);
                  if (m_age == 2 + V) m_mix = MW'(m_sum);
               end
               if (m_age >= 3 + V && mix_ready) nb = 0;
               m_age++;
            end
            if (tick) begin
               if (m_busy) m_ovr = 1;
               else begin
                  nb = 1; m_age = 1; m_en = voice_en; m_sum = 0;
               end
            end
            m_busy = nb;
            m_cnt  = (!enable || m_cnt == CPS - 1) ? 0 : m_cnt + 1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // driver tasks
   // ---------------------------------------------------------------------
   task automatic cyc_drv(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_step();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k > 100) begin
            $display("FAIL step_timeout cycle %0d actual none expected pulse", cyc);
            $fatal(1);
         end
      end while (step == '0);
   endtask

   task automatic wait_valid();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k > 100) begin
            $display("FAIL valid_timeout cycle %0d actual 0 expected 1", cyc);
            $fatal(1);
         end
      end while (!mix_valid);
   endtask

   task automatic wait_hs(input int n, input int budget);
      int got = 0;
      int k   = 0;
      while (got < n) begin
         @(negedge clk);
         k++;
         if (mix_valid && mix_ready) got++;
         if (got < n && k > budget) begin
            $display("FAIL handshake_timeout cycle %0d actual %0d expected %0d", cyc, got, n);
            $fatal(1);
         end
      end
   endtask

   task automatic run(input logic [V-1:0] en, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [MW-1:0] e, input int n);
      voice_en  = en;
      gen_data  = {d1, d0};
      mix_ready = 1'b1;
      for (int k = 0; k < n; k++) exp_q.push_back(e);
      enable = 1'b1;
      wait_hs(n, n * CPS + 30);
      cyc_drv(1);
      enable = 1'b0;
      cyc_drv(5);
   endtask

   // ---------------------------------------------------------------------
   // stimulus
   // ---------------------------------------------------------------------
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      voice_en  = '0;
      gen_data  = '0;
      mix_ready = 1'b1;
      cyc_drv(3);
      reset = 1'b0;

      // reset held 3 cycles in the middle of accumulation, then idle
      voice_en = 2'b11;
      gen_data = {12'h0AA, 12'h055};
      enable   = 1'b1;
      wait_step();
      cyc_drv(2);
      reset  = 1'b1;
      enable = 1'b0;
      cyc_drv(3);
      reset = 1'b0;
      cyc_drv(40);

      // single voice, repeated ticks every 16 cycles
      run(2'b01, 12'h100, 12'h555, 13'h0100, 3);
      // signed mixing
      run(2'b11, 12'h7FF, 12'h7FF, 13'h0FFE, 2);
      run(2'b11, 12'h800, 12'hFFF, 13'h17FF, 1);
      run(2'b01, 12'h800, 12'hFFF, 13'h1800, 1);

      // backpressure: ready low for 40 cycles drops ticks and sets overrun
      voice_en  = 2'b11;
      gen_data  = {12'h010, 12'h123};
      exp_q.push_back(13'h0133);
      exp_q.push_back(13'h0133);
      mix_ready = 1'b0;
      enable    = 1'b1;
      wait_valid();
      cyc_drv(40);
      mix_ready = 1'b1;
      wait_hs(2, 60);
      cyc_drv(1);
      enable = 1'b0;
      reset  = 1'b1;
      cyc_drv(2);
      reset = 1'b0;
      cyc_drv(3);

      // voice enables changed after the tick only affect the next sample
      voice_en = 2'b11;
      gen_data = {12'h002, 12'h001};
      exp_q.push_back(13'h0003);
      exp_q.push_back(13'h0000);
      enable = 1'b1;
      wait_step();
      cyc_drv(1);
      voice_en = 2'b00;
      wait_hs(2, 50);
      cyc_drv(1);
      enable = 1'b0;
      cyc_drv(5);

      // enable dropped right after the tick: in-flight sample completes
      voice_en = 2'b11;
      gen_data = {12'h004, 12'h003};
      exp_q.push_back(13'h0007);
      enable = 1'b1;
      wait_step();
      cyc_drv(1);
      enable = 1'b0;
      wait_hs(1, 20);
      cyc_drv(40);

      done = 1'b1;
   end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sample-rate scheduler and mixer for the wavetable voice generators. It divides the system clock down to the audio sample rate. On each sample tick it issues one single-cycle advance pulse to every enabled voice, waits for the voices' registered outputs to settle, and accumulates them sequentially into one signed mixed sample. That sample is presented to the downstream audio path (DAC/PWM/I2S) over a valid/ready handshake.

## Interface
- width_p, 12: sample width per voice, two's complement.
- voices_p, 4: number of voice generators; must be ≥ 1.
- clk_per_sample_p, 2268: clock cycles per sample tick (100 MHz / 44.1 kHz); must be ≥ voices_p + 4.
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  run the sample-tick counter.
- voice_en_i  in  voices_p  per-voice enable; sampled at the tick.
- gen_data_i  in  voices_p*width_p  voice outputs; voice i occupies bits [i*width_p +: width_p].
- step_o  out  voices_p  per-voice advance pulse; drives the generator's ready_i and valid_i.
- mix_data_o  out  width_p+$clog2(voices_p)  signed mixed sample (mw bits).
- mix_valid_o  out  1  mixed sample valid.
- mix_ready_i  in  1  downstream accepts the sample.
- busy_o  out  1  state machine is not in IDLE.
- overrun_o  out  1  sticky: a tick was dropped.

## Operation
- Tick counter cnt:
  - Resets to 0.
  - When enable_i=1: increments each cycle, wrapping from clk_per_sample_p-1 to 0.
  - tick = enable_i && cnt==clk_per_sample_p-1.
  - When enable_i=0: cnt holds 0 and no ticks occur; an in-flight sample still completes.
- FSM states: IDLE, STEP, SETTLE, ACCUM, OUT.
- IDLE: on tick, latch en_q=voice_en_i, clear acc to 0, go to STEP.
- STEP: step_o=en_q for exactly one cycle; go to SETTLE.
- SETTLE: one cycle for the generator's address and data registers to update; step_o=0; go to ACCUM with idx=0.
- ACCUM, one voice per cycle:
  - acc += en_q[idx] ? sign-extend(gen_data_i[idx]) to mw : 0.
  - Go to OUT after idx=voices_p-1.
- OUT:
  - mix_data_o is a register, loaded with the final acc on entry to OUT; mix_valid_o=1.
  - On mix_valid_o && mix_ready_i, go to IDLE.
  - mix_data_o holds its last value afterwards, until the next load.
- Arithmetic: mw-bit two's complement. voices_p samples of width_p bits cannot overflow mw bits, so there is no saturation logic.
- Tick while not in IDLE (backpressure or small divider):
  - The tick is dropped; overrun_o is set.
  - No step_o pulse is issued for it; the in-flight sample is unaffected.
  - overrun_o clears only on reset_i.
- voice_en_i changes after the tick have no effect until the next accepted tick.
- Disabled voices receive no step_o pulse (their phase freezes) and contribute 0 to the mix.
- Reset in any state, same cycle:
  - state=IDLE, cnt=0, acc=0, en_q=0.
  - All outputs go to 0: step_o, mix_data_o, mix_valid_o, busy_o, overrun_o.

## Timing
- Reset values: every output is 0.
- Tick in cycle T, with V = voices_p:
  - STEP in T+1 (step_o asserted).
  - SETTLE in T+2.
  - ACCUM in T+3 .. T+2+V.
  - mix_valid_o first high in T+3+V (T+7 for V=4).
- The voice i sample is read in cycle T+3+i; gen_data_i need only be stable in that cycle.
- With mix_ready_i held high: handshake in T+3+V, IDLE in T+4+V. busy_o is high from T+1 through T+3+V.
- Tick spacing is exactly clk_per_sample_p cycles while enable_i stays high.
- First tick after reset deassert with enable_i=1: the cycle where cnt reaches clk_per_sample_p-1.
- Tick coinciding with handshake cycle (state still OUT): the tick is dropped and overrun_o is set.

## Test plan
- Reset: hold reset_i 3 cycles mid-ACCUM, then enable_i=0 for 40 cycles -> all outputs 0, step_o never pulses, cnt idle.
- Single voice: voices_p=2, clk_per_sample_p=16, voice_en_i=2'b01, voice0 data 12'h100, mix_ready_i=1.
  - step_o=2'b01 for one cycle at T+1.
  - mix_valid_o at T+5 with mix_data_o=13'h0100.
  - Ticks every 16 cycles.
- Signed mix: voices_p=2, both enabled.
  - 12'h7FF + 12'h7FF -> 13'h0FFE.
  - 12'h800 + 12'hFFF -> 13'h17FF.
  - Voice1 disabled with 12'hFFF -> 13'h1800 for the first case's data 12'h800.
- Backpressure: mix_ready_i=0 for 40 cycles with clk_per_sample_p=16.
  - mix_valid_o and mix_data_o stay stable.
  - overrun_o sets at the next tick, and that tick produces no step_o.
  - After mix_ready_i=1, the next tick is processed normally.
- Enable change: flip voice_en_i from 2'b11 to 2'b00 at T+2 -> the current sample still sums both voices; the next sample is 0 with step_o=0.
- enable_i drop at T+1: the in-flight sample completes and is handshaken; no further ticks occur; cnt=0.
